// File: rtl/sad_ctrl_if.sv
// Control/status bundle between the SAD sequencer, the customSad datapath and the A/B memories.
// The master side is the sequencer; the slave side is the datapath plus memories.
interface sad_ctrl_if;
   logic mem_rd;
   logic mem_ack;
   logic i_inc;
   logic i_clr;
   logic sum_ld;
   logic sum_clr;
   logic sadreg_ld;
   logic sadreg_clr;
   logic i_ld_256;

   modport master (
      output mem_rd, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr,
      input  i_ld_256, mem_ack
   );

   modport slave (
      input  mem_rd, i_inc, i_clr, sum_ld, sum_clr, sadreg_ld, sadreg_clr,
      output i_ld_256, mem_ack
   );
endinterface

// File: rtl/sad_ctrl.sv
// Moore sequencer for the customSad datapath: walks N_ELEMS A/B pairs through
// check/fetch/accumulate, stores the sum and pulses done.
module sad_ctrl #(
   parameter int N_ELEMS = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go,
   input  logic       abort,
   sad_ctrl_if.master dp,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      SADCLR, IDLE, INIT, CHECK, FETCH, ACCUM, STORE, DONE
   } state_t;

   state_t state, state_nxt;

   // The loop bound itself lives in the datapath comparator; only sanity-check it here.
   if (N_ELEMS < 1) begin : g_param_check
      $error("sad_ctrl: N_ELEMS must be at least 1");
   end

   // NOTE: state is a flop, so it is written with <= only; blocking here would race other edge-triggered readers.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= SADCLR;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal written below gets a default first, so no path through the case can infer a latch.
      state_nxt     = state;
      dp.mem_rd     = 1'b0;
      dp.i_inc      = 1'b0;
      dp.i_clr      = 1'b0;
      dp.sum_ld     = 1'b0;
      dp.sum_clr    = 1'b0;
      dp.sadreg_ld  = 1'b0;
      dp.sadreg_clr = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;

      case (state)
         SADCLR: begin
            dp.sadreg_clr = 1'b1;
            state_nxt     = IDLE;
         end
         IDLE: begin
            if (go) state_nxt = INIT;
         end
         INIT: begin
            dp.i_clr   = 1'b1;
            dp.sum_clr = 1'b1;
            busy       = 1'b1;
            state_nxt  = CHECK;
         end
         CHECK: begin
            busy      = 1'b1;
            state_nxt = dp.i_ld_256 ? FETCH : STORE;
         end
         FETCH: begin
            dp.mem_rd = 1'b1;
            busy      = 1'b1;
            if (dp.mem_ack) state_nxt = ACCUM;
         end
         ACCUM: begin
            dp.sum_ld = 1'b1;
            dp.i_inc  = 1'b1;
            busy      = 1'b1;
            state_nxt = CHECK;
         end
         STORE: begin
            dp.sadreg_ld = 1'b1;
            busy         = 1'b1;
            state_nxt    = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = SADCLR;
      endcase

      // busy marks exactly the abortable states, and abort beats every other transition out of them.
      if (abort && busy) state_nxt = IDLE;
   end

endmodule

// File: tb/tb_sad_ctrl.sv
// Self-checking bench for sad_ctrl: a behavioural datapath/memory environment, a per-cycle
// output model, literal timing/result pins, and a randomized phase.
module tb_sad_ctrl;

   typedef struct packed {
      logic mem_rd;
      logic i_inc;
      logic i_clr;
      logic sum_ld;
      logic sum_clr;
      logic sadreg_ld;
      logic sadreg_clr;
      logic busy;
      logic done;
   } outs_t;

   localparam outs_t O_IDLE  = 9'b000000000;
   localparam outs_t O_CLR   = 9'b000000100;
   localparam outs_t O_INIT  = 9'b001010010;
   localparam outs_t O_CHECK = 9'b000000010;
   localparam outs_t O_FETCH = 9'b100000010;
   localparam outs_t O_ACCUM = 9'b010100010;
   localparam outs_t O_STORE = 9'b000001010;
   localparam outs_t O_DONE  = 9'b000000001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;
   logic go    = 1'b0;
   logic abort = 1'b0;
   logic go4   = 1'b0;
   logic busy, done, busy4, done4;

   sad_ctrl_if dpi ();
   sad_ctrl_if dp4 ();

   sad_ctrl #(.N_ELEMS(256)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .dp(dpi), .busy(busy), .done(done)
   );

   sad_ctrl #(.N_ELEMS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .go(go4), .abort(1'b0), .dp(dp4), .busy(busy4), .done(done4)
   );

   // Behavioural customSad datapath and A/B memories
   logic [7:0]  a_mem [256];
   logic [7:0]  b_mem [256];
   int unsigned idx, acc, sad_reg, idx4;

   function automatic int unsigned absdiff(logic [7:0] a, logic [7:0] b);
      return (a > b) ? int'(a - b) : int'(b - a);
   endfunction

   assign dpi.i_ld_256 = (idx < 256);
   assign dp4.i_ld_256 = (idx4 < 4);
   assign dp4.mem_ack  = dp4.mem_rd;

   always @(posedge clk) begin
      if (dpi.i_clr)      idx <= 0;
      else if (dpi.i_inc) idx <= idx + 1;
      if (dpi.sum_clr)     acc <= 0;
      else if (dpi.sum_ld) acc <= acc + absdiff(a_mem[idx[7:0]], b_mem[idx[7:0]]);
      if (dpi.sadreg_clr)     sad_reg <= 0;
      else if (dpi.sadreg_ld) sad_reg <= acc;
      if (dp4.i_clr)      idx4 <= 0;
      else if (dp4.i_inc) idx4 <= idx4 + 1;
   end

   // Bench state
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic        rst_v = 1'b0, go_v = 1'b0, abort_v = 1'b0, go4_v = 1'b0;
   bit          noise = 1'b0;
   int          wait_mode = 0, cur_wait = 0, rd_run = 0;
   outs_t       exp_o, last_act;
   bit          mvalid = 1'b0;
   int          last_done_cyc = 0, n_done = 0, n_mem_rd = 0, n_sum_ld = 0, n_sadreg_ld = 0;
   int          done4_cyc = -1, fetch4 = 0;
   int unsigned exp_sad = 0;

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   // Expected outputs next cycle, from the rules of the sequence and this cycle's inputs.
   function automatic outs_t model_next(outs_t cur, logic r, logic g, logic ab, logic ild, logic ack);
      if (!r) return O_CLR;
      if (cur.busy && ab) return O_IDLE;
      case (cur)
         O_CLR:   return O_IDLE;
         O_IDLE:  return g ? O_INIT : O_IDLE;
         O_INIT:  return O_CHECK;
         O_CHECK: return ild ? O_FETCH : O_STORE;
         O_FETCH: return ack ? O_ACCUM : O_FETCH;
         O_ACCUM: return O_CHECK;
         O_STORE: return O_DONE;
         default: return O_IDLE;
      endcase
   endfunction

   task automatic fill_mem(bit rnd);
      exp_sad = 0;
      for (int i = 0; i < 256; i++) begin
         a_mem[i] = rnd ? 8'($urandom) : 8'd50;
         b_mem[i] = rnd ? 8'($urandom) : 8'd100;
         exp_sad += absdiff(a_mem[i], b_mem[i]);
      end
   endtask

   task automatic clear_counts();
      n_done = 0; n_mem_rd = 0; n_sum_ld = 0; n_sadreg_ld = 0;
      done4_cyc = -1; fetch4 = 0;
   endtask

   // One cycle: observe and compare, then drive this cycle's inputs and advance the model.
   task automatic tick();
      outs_t act;
      logic  ack;
      @(negedge clk);
      act = {dpi.mem_rd, dpi.i_inc, dpi.i_clr, dpi.sum_ld, dpi.sum_clr,
             dpi.sadreg_ld, dpi.sadreg_clr, busy, done};
      last_act = act;
      if (mvalid) check("outs", act, exp_o);
      if (act.done === 1'b1) begin
         last_done_cyc = cyc;
         n_done++;
         check("sad_at_done", sad_reg, exp_sad);
      end
      if (act.mem_rd === 1'b1)    n_mem_rd++;
      if (act.sum_ld === 1'b1)    n_sum_ld++;
      if (act.sadreg_ld === 1'b1) n_sadreg_ld++;
      if (done4 === 1'b1 && done4_cyc < 0) done4_cyc = cyc;
      if (dp4.mem_rd === 1'b1) fetch4++;

      if (dpi.mem_rd === 1'b1) begin
         ack    = (rd_run >= cur_wait);
         rd_run = ack ? 0 : rd_run + 1;
         if (ack) cur_wait = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
      end else begin
         ack    = noise ? 1'($urandom) : 1'b0;
         rd_run = 0;
      end
      dpi.mem_ack = ack;
      rst_n = rst_v;
      go    = go_v;
      abort = abort_v;
      go4   = go4_v;
      exp_o  = model_next(exp_o, rst_v, go_v, abort_v, dpi.i_ld_256, ack);
      mvalid = 1'b1;
      cyc++;
   endtask

   task automatic wait_done(int budget);
      int start = n_done;
      int k = 0;
      while (n_done == start && k < budget) begin
         tick();
         k++;
      end
      check("done_seen", n_done - start, 1);
   endtask

   initial begin
      int c0, d1, d2;
      dpi.mem_ack = 1'b0;
      fill_mem(1'b0);

      // Reset held two cycles, then released
      tick();
      tick();
      check("rst_clr", last_act, O_CLR);
      rst_v = 1'b1;
      tick();
      check("rst_release_clr", last_act, O_CLR);
      tick();
      check("rst_idle", last_act, O_IDLE);
      check("rst_sad", sad_reg, 0);

      // Full run, zero wait; the N_ELEMS=4 instance starts in the same cycle
      clear_counts();
      c0 = cyc;
      go_v = 1'b1; go4_v = 1'b1;
      tick();
      go_v = 1'b0; go4_v = 1'b0;
      wait_done(1000);
      check("done_cycle_zero_wait", last_done_cyc - c0, 772);
      check("mem_rd_count", n_mem_rd, 256);
      check("sum_ld_count", n_sum_ld, 256);
      check("sadreg_ld_count", n_sadreg_ld, 1);
      check("sad_full", sad_reg, 12800);
      check("n4_done_cycle", done4_cyc - c0, 16);
      check("n4_fetches", fetch4, 4);
      repeat (3) tick();

      // Two wait states per element, with a stray go mid-run
      wait_mode = 2; cur_wait = 2; rd_run = 0;
      clear_counts();
      c0 = cyc;
      go_v = 1'b1;
      tick();
      go_v = 1'b0;
      repeat (99) tick();
      go_v = 1'b1;
      tick();
      go_v = 1'b0;
      wait_done(2000);
      check("done_cycle_wait2", last_done_cyc - c0, 1284);
      check("mem_rd_cycles_wait2", n_mem_rd, 768);
      check("sum_ld_count_wait2", n_sum_ld, 256);
      repeat (3) tick();

      // Abort during the 10th fetch
      wait_mode = 0; cur_wait = 0;
      clear_counts();
      c0 = cyc;
      go_v = 1'b1;
      tick();
      go_v = 1'b0;
      repeat (29) tick();
      abort_v = 1'b1;
      tick();
      abort_v = 1'b0;
      check("abort_in_fetch", last_act, O_FETCH);
      check("abort_fetch_index", n_mem_rd, 10);
      tick();
      check("abort_to_idle", last_act, O_IDLE);
      repeat (800) tick();
      check("abort_no_done", n_done, 0);
      check("abort_no_sadreg_ld", n_sadreg_ld, 0);
      check("abort_sad_kept", sad_reg, 12800);

      // Restart after abort on fresh random data
      fill_mem(1'b1);
      clear_counts();
      c0 = cyc;
      go_v = 1'b1;
      tick();
      go_v = 1'b0;
      wait_done(1000);
      check("done_cycle_after_abort", last_done_cyc - c0, 772);
      check("sad_random", sad_reg, exp_sad);
      repeat (2) tick();

      // go held high: back-to-back runs
      go_v = 1'b1;
      wait_done(1000);
      d1 = last_done_cyc;
      wait_done(1000);
      d2 = last_done_cyc;
      go_v = 1'b0;
      check("back_to_back_period", d2 - d1, 773);
      repeat (3) tick();

      // Randomized phase: random wait states, stray acks, go, abort and occasional reset
      wait_mode = -1;
      cur_wait  = $urandom_range(0, 3);
      noise     = 1'b1;
      for (int i = 0; i < 15000; i++) begin
         go_v    = ($urandom_range(0, 7) == 0);
         abort_v = ($urandom_range(0, 1499) == 0);
         rst_v   = ($urandom_range(0, 5999) != 0);
         tick();
      end
      go_v = 1'b0; abort_v = 1'b0; rst_v = 1'b1;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
